// File: rtl/run_control_if.sv
// Bundles the trigger, watchdog, decode-side inputs and the fetch/status outputs of run_control.
interface run_control_if #(
    parameter int unsigned CYCLE_CNT_W = 32,
    parameter int unsigned WATCHDOG_W  = 16
);
    logic                   first_fetch_trigger;
    logic [WATCHDOG_W-1:0]  watchdog_limit;
    logic                   decode_valid;
    logic [31:0]            decode_instruction;
    logic                   pc_load;
    logic [31:0]            pc_load_val;
    logic                   fetch_en;
    logic                   busy;
    logic                   halted;
    logic                   timeout;
    logic [CYCLE_CNT_W-1:0] cycle_count;
    logic [CYCLE_CNT_W-1:0] instr_count;

    modport slave (
        input  first_fetch_trigger, watchdog_limit, decode_valid, decode_instruction,
        output pc_load, pc_load_val, fetch_en, busy, halted, timeout, cycle_count, instr_count
    );

    modport master (
        output first_fetch_trigger, watchdog_limit, decode_valid, decode_instruction,
        input  pc_load, pc_load_val, fetch_en, busy, halted, timeout, cycle_count, instr_count
    );
endinterface

// File: rtl/run_control.sv
// Launches fetch on the start trigger, stops it on the end-of-test self-loop at decode
// or when the no-progress watchdog expires, and exports run status and counters.
module run_control #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR  = 32'h0000_006f,
    parameter int unsigned CYCLE_CNT_W = 32,
    parameter int unsigned WATCHDOG_W  = 16
) (
    input  logic          clk,
    input  logic          rstn,
    run_control_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_RUN     = 3'd2,
        S_HALTED  = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_pc_load;
    logic                   r_fetch_en;
    logic                   r_busy;
    logic                   r_halted;
    logic                   r_timeout;
    logic [CYCLE_CNT_W-1:0] r_cycle_count;
    logic [CYCLE_CNT_W-1:0] r_instr_count;
    logic [WATCHDOG_W-1:0]  r_idle_cnt;

    logic                   w_halt_hit;
    logic                   w_wd_expire;
    logic                   w_enter_launch;

    assign w_halt_hit  = bus.decode_valid && (bus.decode_instruction == HALT_INSTR);
    assign w_wd_expire = !bus.decode_valid && (bus.watchdog_limit != '0) &&
                         (r_idle_cnt == bus.watchdog_limit - WATCHDOG_W'(1));

    // Next-state decode; halt is checked ahead of the watchdog so it wins a tie
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_HALTED, S_TIMEOUT: begin
                if (bus.first_fetch_trigger) w_state_nxt = S_LAUNCH;
            end
            S_LAUNCH: w_state_nxt = S_RUN;
            S_RUN: begin
                if (w_halt_hit)       w_state_nxt = S_HALTED;
                else if (w_wd_expire) w_state_nxt = S_TIMEOUT;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_enter_launch = (w_state_nxt == S_LAUNCH) && (r_state != S_LAUNCH);

    // State and status flags registered from the next state so they align with it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_pc_load  <= 1'b0;
            r_fetch_en <= 1'b0;
            r_busy     <= 1'b0;
            r_halted   <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc_load  <= (w_state_nxt == S_LAUNCH);
            r_fetch_en <= (w_state_nxt == S_RUN);
            r_busy     <= (w_state_nxt == S_LAUNCH) || (w_state_nxt == S_RUN);
            r_halted   <= (w_state_nxt == S_HALTED);
            r_timeout  <= (w_state_nxt == S_TIMEOUT);
        end
    end

    // Saturating run counters and the no-progress idle counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cycle_count <= '0;
            r_instr_count <= '0;
            r_idle_cnt    <= '0;
        end else if (w_enter_launch) begin
            r_cycle_count <= '0;
            r_instr_count <= '0;
            r_idle_cnt    <= '0;
        end else begin
            if (((r_state == S_LAUNCH) || (r_state == S_RUN)) && (r_cycle_count != '1))
                r_cycle_count <= r_cycle_count + CYCLE_CNT_W'(1);
            if ((r_state == S_RUN) && bus.decode_valid && !w_halt_hit && (r_instr_count != '1))
                r_instr_count <= r_instr_count + CYCLE_CNT_W'(1);
            if (r_state == S_RUN) begin
                if (bus.decode_valid)        r_idle_cnt <= '0;
                else if (r_idle_cnt != '1)   r_idle_cnt <= r_idle_cnt + WATCHDOG_W'(1);
            end
        end
    end

    assign bus.pc_load     = r_pc_load;
    assign bus.pc_load_val = RESET_PC;
    assign bus.fetch_en    = r_fetch_en;
    assign bus.busy        = r_busy;
    assign bus.halted      = r_halted;
    assign bus.timeout     = r_timeout;
    assign bus.cycle_count = r_cycle_count;
    assign bus.instr_count = r_instr_count;

endmodule

// File: tb/tb_run_control.sv
// Directed bench for run_control: launch, halt, watchdog, tie-break, restart, saturation, async reset.
module tb_run_control;

    logic clk;
    logic rstn;
    logic rstn4;
    int   checks;
    int   failures;

    run_control_if #(.CYCLE_CNT_W(32), .WATCHDOG_W(16)) bus  ();
    run_control_if #(.CYCLE_CNT_W(4),  .WATCHDOG_W(16)) bus4 ();

    run_control #(.RESET_PC(32'h0000_0000), .HALT_INSTR(32'h0000_006f),
                  .CYCLE_CNT_W(32), .WATCHDOG_W(16)) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    run_control #(.RESET_PC(32'h0000_0000), .HALT_INSTR(32'h0000_006f),
                  .CYCLE_CNT_W(4), .WATCHDOG_W(16)) u_dut4 (
        .clk  (clk),
        .rstn (rstn4),
        .bus  (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.first_fetch_trigger = 1'b0;
        bus.watchdog_limit      = 16'd0;
        bus.decode_valid        = 1'b0;
        bus.decode_instruction  = 32'h0;
        #2;
        checks++;
        if ({bus.pc_load, bus.fetch_en, bus.busy, bus.halted, bus.timeout} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000",
                     {bus.pc_load, bus.fetch_en, bus.busy, bus.halted, bus.timeout});
        end
        checks++;
        if (bus.cycle_count !== 32'd0 || bus.instr_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_counters got=%0d/%0d exp=0/0", bus.cycle_count, bus.instr_count);
        end
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_launch();
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.pc_load !== 1'b0) begin
            failures++;
            $display("FAIL idle_before_trigger busy=%b pc_load=%b exp=0/0", bus.busy, bus.pc_load);
        end
        bus.first_fetch_trigger = 1'b1;
        tick();
        bus.first_fetch_trigger = 1'b0;
        checks++;
        if (bus.pc_load !== 1'b1 || bus.fetch_en !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL launch_cycle pc_load=%b fetch_en=%b busy=%b exp=1/0/1",
                     bus.pc_load, bus.fetch_en, bus.busy);
        end
        checks++;
        if (bus.pc_load_val !== 32'h0) begin
            failures++;
            $display("FAIL pc_load_val got=%h exp=00000000", bus.pc_load_val);
        end
        tick();
        checks++;
        if (bus.pc_load !== 1'b0 || bus.fetch_en !== 1'b1 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL run_entry pc_load=%b fetch_en=%b busy=%b exp=0/1/1",
                     bus.pc_load, bus.fetch_en, bus.busy);
        end
        checks++;
        if (bus.cycle_count !== 32'd1) begin
            failures++;
            $display("FAIL cycle_count_run1 got=%0d exp=1", bus.cycle_count);
        end
    endtask

    // In RUN cycle 1: ten words then halt in RUN cycle 11 -> 1 LAUNCH + 11 RUN cycles counted
    task automatic test_halt();
        for (int i = 0; i < 10; i++) begin
            bus.decode_valid       = 1'b1;
            bus.decode_instruction = 32'h0000_0013 + 32'(i) * 32'h100;
            tick();
        end
        checks++;
        if (bus.instr_count !== 32'd10 || bus.fetch_en !== 1'b1) begin
            failures++;
            $display("FAIL pre_halt instr=%0d fetch_en=%b exp=10/1", bus.instr_count, bus.fetch_en);
        end
        bus.decode_instruction = 32'h0000_006f;
        tick();
        bus.decode_valid       = 1'b0;
        bus.decode_instruction = 32'h0;
        checks++;
        if (bus.halted !== 1'b1 || bus.fetch_en !== 1'b0 || bus.timeout !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL halt_flags halted=%b fetch_en=%b timeout=%b busy=%b exp=1/0/0/0",
                     bus.halted, bus.fetch_en, bus.timeout, bus.busy);
        end
        checks++;
        if (bus.instr_count !== 32'd10 || bus.cycle_count !== 32'd12) begin
            failures++;
            $display("FAIL halt_counts instr=%0d cycle=%0d exp=10/12", bus.instr_count, bus.cycle_count);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (bus.cycle_count !== 32'd12 || bus.halted !== 1'b1) begin
            failures++;
            $display("FAIL halt_frozen cycle=%0d halted=%b exp=12/1", bus.cycle_count, bus.halted);
        end
    endtask

    task automatic test_watchdog();
        bus.watchdog_limit      = 16'd8;
        bus.first_fetch_trigger = 1'b1;
        tick();
        bus.first_fetch_trigger = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (bus.timeout !== 1'b0 || bus.fetch_en !== 1'b1) begin
            failures++;
            $display("FAIL wd_run8 timeout=%b fetch_en=%b exp=0/1", bus.timeout, bus.fetch_en);
        end
        tick();
        checks++;
        if (bus.timeout !== 1'b1 || bus.halted !== 1'b0 || bus.fetch_en !== 1'b0) begin
            failures++;
            $display("FAIL wd_expired timeout=%b halted=%b fetch_en=%b exp=1/0/0",
                     bus.timeout, bus.halted, bus.fetch_en);
        end
        checks++;
        if (bus.cycle_count !== 32'd9) begin
            failures++;
            $display("FAIL wd_cycle_count got=%0d exp=9", bus.cycle_count);
        end
    endtask

    task automatic test_halt_vs_watchdog();
        bus.watchdog_limit      = 16'd4;
        bus.first_fetch_trigger = 1'b1;
        tick();
        bus.first_fetch_trigger = 1'b0;
        checks++;
        if (bus.timeout !== 1'b0 || bus.pc_load !== 1'b1) begin
            failures++;
            $display("FAIL relaunch_from_timeout timeout=%b pc_load=%b exp=0/1", bus.timeout, bus.pc_load);
        end
        for (int i = 0; i < 4; i++) tick();
        bus.decode_valid       = 1'b1;
        bus.decode_instruction = 32'h0000_006f;
        tick();
        bus.decode_valid       = 1'b0;
        bus.decode_instruction = 32'h0;
        checks++;
        if (bus.halted !== 1'b1 || bus.timeout !== 1'b0) begin
            failures++;
            $display("FAIL tie_break halted=%b timeout=%b exp=1/0", bus.halted, bus.timeout);
        end
        checks++;
        if (bus.instr_count !== 32'd0 || bus.cycle_count !== 32'd5) begin
            failures++;
            $display("FAIL tie_counts instr=%0d cycle=%0d exp=0/5", bus.instr_count, bus.cycle_count);
        end
    endtask

    // Stale halt word held through LAUNCH and trigger held into RUN must both be ignored
    task automatic test_restart();
        bus.watchdog_limit      = 16'd0;
        bus.first_fetch_trigger = 1'b1;
        bus.decode_valid        = 1'b1;
        bus.decode_instruction  = 32'h0000_006f;
        tick();
        checks++;
        if (bus.pc_load !== 1'b1 || bus.halted !== 1'b0 ||
            bus.cycle_count !== 32'd0 || bus.instr_count !== 32'd0) begin
            failures++;
            $display("FAIL restart_launch pc_load=%b halted=%b cycle=%0d instr=%0d exp=1/0/0/0",
                     bus.pc_load, bus.halted, bus.cycle_count, bus.instr_count);
        end
        tick();
        bus.decode_valid       = 1'b0;
        bus.decode_instruction = 32'h0;
        checks++;
        if (bus.fetch_en !== 1'b1 || bus.halted !== 1'b0 || bus.pc_load !== 1'b0) begin
            failures++;
            $display("FAIL stale_halt_ignored fetch_en=%b halted=%b pc_load=%b exp=1/0/0",
                     bus.fetch_en, bus.halted, bus.pc_load);
        end
        tick();
        bus.first_fetch_trigger = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.pc_load !== 1'b0 || bus.cycle_count !== 32'd2 ||
            bus.instr_count !== 32'd0) begin
            failures++;
            $display("FAIL trigger_in_run busy=%b pc_load=%b cycle=%0d instr=%0d exp=1/0/2/0",
                     bus.busy, bus.pc_load, bus.cycle_count, bus.instr_count);
        end
    endtask

    task automatic test_saturate_and_reset();
        bus4.first_fetch_trigger = 1'b0;
        bus4.watchdog_limit      = 16'd0;
        bus4.decode_valid        = 1'b0;
        bus4.decode_instruction  = 32'h0;
        rstn4 = 1'b1;
        tick();
        bus4.first_fetch_trigger = 1'b1;
        tick();
        bus4.first_fetch_trigger = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (bus4.cycle_count !== 4'd10) begin
            failures++;
            $display("FAIL sat_mid got=%0d exp=10", bus4.cycle_count);
        end
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (bus4.cycle_count !== 4'd15 || bus4.fetch_en !== 1'b1) begin
            failures++;
            $display("FAIL sat_cycle_count got=%0d fetch_en=%b exp=15/1", bus4.cycle_count, bus4.fetch_en);
        end
        #3;
        rstn4 = 1'b0;
        #1;
        checks++;
        if ({bus4.pc_load, bus4.fetch_en, bus4.busy, bus4.halted, bus4.timeout} !== 5'b0 ||
            bus4.cycle_count !== 4'd0 || bus4.instr_count !== 4'd0) begin
            failures++;
            $display("FAIL async_reset flags=%b cycle=%0d instr=%0d exp=00000/0/0",
                     {bus4.pc_load, bus4.fetch_en, bus4.busy, bus4.halted, bus4.timeout},
                     bus4.cycle_count, bus4.instr_count);
        end
        tick();
        rstn4 = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (bus4.busy !== 1'b0 || bus4.fetch_en !== 1'b0 || bus4.cycle_count !== 4'd0) begin
            failures++;
            $display("FAIL idle_after_reset busy=%b fetch_en=%b cycle=%0d exp=0/0/0",
                     bus4.busy, bus4.fetch_en, bus4.cycle_count);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rstn4    = 1'b0;
        bus4.first_fetch_trigger = 1'b0;
        bus4.watchdog_limit      = 16'd0;
        bus4.decode_valid        = 1'b0;
        bus4.decode_instruction  = 32'h0;
        test_reset();
        test_launch();
        test_halt();
        test_watchdog();
        test_halt_vs_watchdog();
        test_restart();
        test_saturate_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
